// File: rtl/mem_arbiter_nch_if.sv
// mem_arbiter_nch_if: client request/response channels plus the byte-serial memory bus.
interface mem_arbiter_nch_if #(parameter int NCH = 2);
    logic [NCH-1:0]    req;
    logic [NCH*32-1:0] req_addr;
    logic [NCH-1:0]    req_rw;
    logic [NCH*2-1:0]  req_size;
    logic [NCH-1:0]    req_sext;
    logic [NCH*32-1:0] req_wdata;
    logic [NCH-1:0]    done;
    logic [NCH*32-1:0] rdata;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [31:0]       mem_a;
    logic              mem_wr;
    logic              io_buffer_full;
    modport slave (
        input  req, req_addr, req_rw, req_size, req_sext, req_wdata, mem_din, io_buffer_full,
        output done, rdata, mem_dout, mem_a, mem_wr
    );
    modport master (
        output req, req_addr, req_rw, req_size, req_sext, req_wdata, mem_din, io_buffer_full,
        input  done, rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: N-channel arbiter serialising byte/half/word/fetch requests onto an 8-bit bus.
module mem_arbiter_nch #(
    parameter int             NCH        = 2,
    parameter int             ARB_MODE   = 0,
    parameter logic [NCH-1:0] FLUSH_MASK = {NCH{1'b1}},
    parameter logic [1:0]     IO_SEL     = 2'b11
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_pipline,
    mem_arbiter_nch_if.slave bus,
    output logic             busy
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    typedef enum logic [1:0] {IDLE, ADDR, TAIL} state_t;
    state_t state, state_nx;
    logic [CW-1:0] ch, ptr, gnt;
    logic [CW:0] pos;
    logic [31:0] addr, wdata, data, full, res, a;
    logic [1:0] size, idx;
    logic [NCH-1:0] elig, cur, done_q;
    logic [NCH*32-1:0] rdata_q;
    logic rw, sext, sx, found, last, stall, step, wr_done, abort, grant_ok;

    assign a = addr + {30'd0, idx};
    assign stall = state == ADDR && rw && a[17:16] == IO_SEL && bus.io_buffer_full;
    assign step = state == ADDR && !stall;
    // a fetch learns its length from byte0, which is on mem_din during address idx 1
    assign last = size == 2'b00 ? idx == 2'd0 :
                  size == 2'b01 ? idx == 2'd1 :
                  size == 2'b10 ? idx == 2'd3 :
                  idx == 2'd3 || (idx == 2'd1 && bus.mem_din[1:0] != 2'b11);
    assign wr_done = step && rw && last;
    assign abort = rdy_in && flush_pipline && state != IDLE && !rw && FLUSH_MASK[ch];
    assign cur = state == IDLE ? '0 : NCH'(1) << ch;
    assign elig = bus.req & ~done_q & ~cur & ~(rdy_in && flush_pipline ? FLUSH_MASK : '0);
    assign grant_ok = rdy_in && found && (state == IDLE || (state == TAIL && !abort) || wr_done);
    assign sx = sext && !size[1];
    assign busy = state != IDLE;
    assign bus.mem_a = state == ADDR ? a : '0;
    assign bus.mem_dout = state == ADDR && rw ? wdata[{idx, 3'b000} +: 8] : '0;
    assign bus.mem_wr = state == ADDR && rw && !stall && rdy_in;
    assign bus.done = done_q;
    assign bus.rdata = rdata_q;

    always_comb begin
        found = 1'b0;
        gnt = '0;
        pos = '0;
        for (int i = 0; i < NCH; i++) begin
            pos = (ARB_MODE != 0 ? {1'b0, ptr} : '0) + (CW+1)'(i);
            pos = pos >= (CW+1)'(NCH) ? pos - (CW+1)'(NCH) : pos;
            if (!found && elig[pos[CW-1:0]]) begin
                found = 1'b1;
                gnt = pos[CW-1:0];
            end
        end
    end

    always_comb begin
        full = data;
        full[{idx, 3'b000} +: 8] = bus.mem_din;
        res = idx == 2'd0 ? {{24{sx & full[7]}}, full[7:0]} :
              idx == 2'd1 ? {{16{sx & full[15]}}, full[15:0]} : full;
    end

    always_comb begin
        state_nx = state;
        state_nx = abort ? IDLE :
                   grant_ok ? ADDR :
                   state == TAIL ? IDLE :
                   step && last ? (rw ? IDLE : TAIL) : state;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            ch <= '0;
            ptr <= '0;
            addr <= '0;
            wdata <= '0;
            data <= '0;
            size <= '0;
            idx <= '0;
            rw <= 1'b0;
            sext <= 1'b0;
            done_q <= '0;
            rdata_q <= '0;
        end else if (rdy_in) begin
            state <= state_nx;
            done_q <= '0;
            if (state == ADDR && !rw && idx != 2'd0) data[{idx - 2'd1, 3'b000} +: 8] <= bus.mem_din;
            if (step && !last) idx <= idx + 2'd1;
            if (state == TAIL && !abort) begin
                done_q[ch] <= 1'b1;
                rdata_q[ch*32 +: 32] <= res;
            end
            if (wr_done) done_q[ch] <= 1'b1;
            if (grant_ok) begin
                ch <= gnt;
                ptr <= gnt == CW'(NCH - 1) ? '0 : gnt + 1'b1;
                addr <= bus.req_addr[gnt*32 +: 32];
                rw <= bus.req_rw[gnt];
                size <= bus.req_size[gnt*2 +: 2];
                sext <= bus.req_sext[gnt];
                wdata <= bus.req_wdata[gnt*32 +: 32];
                idx <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_nch.sv
// tb_mem_arbiter_nch: directed checks of priority, extension, fetch length, IO stall, flush and round-robin.
module tb_mem_arbiter_nch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic flush = 1'b0;
    logic busy0, busy1;
    logic [7:0] mem [0:511];
    int n_tests = 0;
    int n_fail = 0;

    mem_arbiter_nch_if #(.NCH(2)) b0();
    mem_arbiter_nch_if #(.NCH(3)) b1();

    mem_arbiter_nch #(.NCH(2), .ARB_MODE(0), .FLUSH_MASK(2'b01)) u0 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_pipline(flush), .bus(b0.slave), .busy(busy0)
    );
    mem_arbiter_nch #(.NCH(3), .ARB_MODE(1)) u1 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_pipline(flush), .bus(b1.slave), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        b0.mem_din <= mem[b0.mem_a[8:0]];
        b1.mem_din <= mem[b1.mem_a[8:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_req(input int c, input logic [31:0] a, input logic rw, input logic [1:0] sz,
                            input logic sx, input logic [31:0] wd);
        b0.req_addr[c*32 +: 32] = a;
        b0.req_rw[c] = rw;
        b0.req_size[c*2 +: 2] = sz;
        b0.req_sext[c] = sx;
        b0.req_wdata[c*32 +: 32] = wd;
    endtask

    task automatic txn(input string tag, input int c, input logic [31:0] a, input logic rw, input logic [1:0] sz,
                       input logic sx, input int exp_cyc, input logic [31:0] exp_rd);
        int cyc;
        load_req(c, a, rw, sz, sx, 32'h0);
        b0.req[c] = 1'b1;
        cyc = 0;
        while (!b0.done[c] && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_cyc"}, cyc, exp_cyc);
        if (!rw) check({tag, "_rd"}, b0.rdata[c*32 +: 32], exp_rd);
        b0.req[c] = 1'b0;
        tick();
    endtask

    logic [31:0] io_a  [8] = '{32'h30000, 32'h30001, 32'h30001, 32'h30001, 32'h30001, 32'h30002, 32'h30003, 32'h0};
    logic [7:0]  io_d  [8] = '{8'hDD, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hBB, 8'hAA, 8'h00};
    logic        io_wr [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rr_a  [4] = '{32'h100, 32'h101, 32'h102, 32'h100};

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h100] = 8'h11; mem[9'h101] = 8'h22; mem[9'h102] = 8'h33; mem[9'h103] = 8'h44;
        mem[9'h020] = 8'h80; mem[9'h021] = 8'h90;
        b0.req = '0; b0.req_addr = '0; b0.req_rw = '0; b0.req_size = '0; b0.req_sext = '0; b0.req_wdata = '0;
        b1.req = '0; b1.req_addr = '0; b1.req_rw = '0; b1.req_size = '0; b1.req_sext = '0; b1.req_wdata = '0;
        b0.io_buffer_full = 1'b0;
        b1.io_buffer_full = 1'b0;
        tick();
        tick();
        check("rst_a", b0.mem_a, 32'h0);
        check("rst_wr", {31'd0, b0.mem_wr}, 32'h0);
        check("rst_dout", {24'd0, b0.mem_dout}, 32'h0);
        check("rst_done", {30'd0, b0.done}, 32'h0);
        check("rst_rdata", b0.rdata[31:0], 32'h0);
        check("rst_busy", {31'd0, busy0}, 32'h0);
        rst = 1'b0;
        tick();

        load_req(0, 32'h100, 1'b0, 2'b10, 1'b0, 32'h0);
        load_req(1, 32'h20, 1'b0, 2'b00, 1'b0, 32'h0);
        b0.req = 2'b11;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("fp_addr", b0.mem_a, 32'h100 + 32'(c) - 32'd1);
        end
        tick();
        check("fp_tail_a", b0.mem_a, 32'h0);
        check("fp_tail_done", {30'd0, b0.done}, 32'h0);
        tick();
        check("fp_done0", {30'd0, b0.done}, 32'h1);
        check("fp_rd0", b0.rdata[31:0], 32'h44332211);
        check("fp_ch1_a", b0.mem_a, 32'h20);
        b0.req[0] = 1'b0;
        tick();
        tick();
        check("fp_done1", {30'd0, b0.done}, 32'h2);
        check("fp_rd1", b0.rdata[63:32], 32'h80);
        b0.req[1] = 1'b0;
        tick();

        txn("half_sx", 0, 32'h20, 1'b0, 2'b01, 1'b1, 4, 32'hFFFF9080);
        txn("byte_sx", 0, 32'h20, 1'b0, 2'b00, 1'b1, 3, 32'hFFFFFF80);
        txn("byte_zx", 0, 32'h20, 1'b0, 2'b00, 1'b0, 3, 32'h00000080);
        mem[0] = 8'h01; mem[1] = 8'h45;
        txn("fetch2", 0, 32'h0, 1'b0, 2'b11, 1'b0, 4, 32'h00004501);
        mem[0] = 8'h13; mem[1] = 8'h00;
        txn("fetch4", 0, 32'h0, 1'b0, 2'b11, 1'b0, 6, 32'h00000013);

        load_req(0, 32'h30000, 1'b1, 2'b10, 1'b0, 32'hAABBCCDD);
        b0.req[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            b0.io_buffer_full = k >= 2 && k <= 4;
            #1;
            check("io_wr", {31'd0, b0.mem_wr}, {31'd0, io_wr[k-1]});
            check("io_a", b0.mem_a, io_a[k-1]);
            check("io_dout", {24'd0, b0.mem_dout}, {24'd0, io_d[k-1]});
            check("io_done", {31'd0, b0.done[0]}, k == 8 ? 32'd1 : 32'd0);
        end
        b0.req[0] = 1'b0;
        tick();

        load_req(0, 32'h100, 1'b0, 2'b10, 1'b0, 32'h0);
        b0.req[0] = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        check("fl_busy2", {31'd0, busy0}, 32'h1);
        tick();
        flush = 1'b0;
        b0.req[0] = 1'b0;
        check("fl_idle", {31'd0, busy0}, 32'h0);
        check("fl_nodone3", {30'd0, b0.done}, 32'h0);
        tick();
        tick();
        tick();
        check("fl_nodone6", {30'd0, b0.done}, 32'h0);
        check("fl_rd_kept", b0.rdata[31:0], 32'h00000013);

        load_req(0, 32'h40, 1'b1, 2'b00, 1'b0, 32'h0000005A);
        load_req(1, 32'h21, 1'b0, 2'b00, 1'b0, 32'h0);
        b0.req = 2'b11;
        tick();
        flush = 1'b1;
        #1;
        check("flw_wr", {31'd0, b0.mem_wr}, 32'h1);
        check("flw_dout", {24'd0, b0.mem_dout}, 32'h5A);
        tick();
        check("flw_done", {30'd0, b0.done}, 32'h1);
        check("flw_ch1_a", b0.mem_a, 32'h21);
        b0.req[0] = 1'b0;
        tick();
        flush = 1'b0;
        tick();
        check("flw_done1", {30'd0, b0.done}, 32'h2);
        check("flw_rd1", b0.rdata[63:32], 32'h90);
        b0.req[1] = 1'b0;
        tick();

        b1.req_addr = {32'h102, 32'h101, 32'h100};
        b1.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_a", b1.mem_a, rr_a[k]);
            if (k < 3) tick();
        end
        check("rr_done2", {29'd0, b1.done}, 32'h4);
        check("rr_rd1", b1.rdata[63:32], 32'h22);
        rst = 1'b1;
        #1;
        check("arst_a", b1.mem_a, 32'h0);
        check("arst_busy", {31'd0, busy1}, 32'h0);
        check("arst_done", {29'd0, b1.done}, 32'h0);
        check("arst_rdata", {31'd0, |b1.rdata}, 32'h0);
        b1.req = '0;
        tick();
        rst = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_nch.md
# mem_arbiter_nch

Parametrised N-channel, byte-serial memory arbiter sitting between the CPU's memory clients (instruction fetch, load/store unit, future DMA/debug ports) and the single 8-bit RAM/IO bus. It accepts byte, half, word and variable-length instruction-fetch requests and serialises them onto the bus one byte per cycle. Arbitration is fixed-priority or round-robin. Loads are sign/zero-extended, and IO writes stall on a full UART buffer. A pipeline flush cancels only the channels selected by a mask, while in-flight writes always run to completion.

## Interface
- NCH, 2: number of requesting channels (1..8); channel 0 is index 0 of every packed bus.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- FLUSH_MASK, {NCH{1'b1}}: channels whose read transactions are cancelled by flush_pipline.
- IO_SEL, 2'b11: value of address bits [17:16] that selects the IO region.
- clk_in  in  1  system clock; all state updates on rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- flush_pipline  in  1  cancel masked reads, see Operation.
- mem_din  in  8  read data; valid the cycle after its address.
- mem_dout  out  8  write data byte.
- mem_a  out  32  byte address; only bits [17:0] are decoded.
- mem_wr  out  1  1 = write this cycle.
- io_buffer_full  in  1  UART buffer full.
- req  in  NCH  per-channel request, level, held until done.
- req_addr  in  NCH*32  start byte address.
- req_rw  in  NCH  0 = read, 1 = write.
- req_size  in  NCH*2  00 = byte, 01 = half, 10 = word, 11 = instruction fetch (2 or 4 bytes).
- req_sext  in  NCH  sign-extend byte/half reads.
- req_wdata  in  NCH*32  write data, little-endian.
- done  out  NCH  one-cycle completion pulse.
- rdata  out  NCH*32  read result; held until that channel's next done.
- busy  out  1  a transaction is in address or tail phase.

## Operation
- States: IDLE, ADDR (drive byte idx), TAIL (capture the last read byte), DONE-pulse (registered).
- Arbitration runs in IDLE and in TAIL. Eligible channels have req=1, done=0 this cycle, and are not flush-blocked. On grant, the channel's addr/rw/size/sext/wdata are latched and the arbiter goes to ADDR with idx=0.
- Round-robin: the search starts at the channel after the last granted one. The pointer resets to 0.
- ADDR drives mem_a = addr+idx.
  - Writes: mem_dout = wdata byte idx, and mem_wr = 1 unless stalled.
  - When idx reaches the last byte: reads go to TAIL; writes go to IDLE (or re-grant) and pulse done.
- Read capture: the byte for idx k arrives on mem_din in the cycle after address idx k. It is captured into byte k.
- Byte count: 1/2/4 for sizes 00/01/10. Size 11 is 2 bytes if captured byte0[1:0] != 2'b11, else 4. The decision is made when byte0 arrives, i.e. during address idx 1.
- Result: unfilled upper bytes are zero, or copies of the top captured bit when sext=1 (sizes 00/01 only).
- IO stall: a write with mem_a[17:16] == IO_SEL while io_buffer_full=1 forces mem_wr=0 and idx holds. Reads never stall.
- Flush (rdy_in=1):
  - An in-progress read of a FLUSH_MASK channel aborts to IDLE with no done and no rdata update.
  - Masked channels are not granted in the flush cycle.
  - Writes and unmasked channels are unaffected.
- rdy_in=0: all state is frozen and mem_wr is forced to 0.
- Outputs outside ADDR: mem_a = 0, mem_dout = 0, mem_wr = 0.

## Timing
- Reset values: mem_a 0, mem_dout 0, mem_wr 0, done 0, rdata 0, busy 0, state IDLE, RR pointer 0.
- Read of n bytes, req seen in IDLE at cycle 0:
  - address cycles 1..n;
  - TAIL at cycle n+1;
  - done and rdata valid at cycle n+2.
- Write of n bytes: address cycles 1..n, done at cycle n+1. Each IO stall cycle adds 1.
- Grant in TAIL makes the next transaction's first address cycle immediately follow TAIL, giving zero bus idle.
- A channel is never re-granted in the cycle its done is high; its req in that cycle is ignored.
- Simultaneous flush and last write byte: the write completes and done pulses.

## Test plan
- Fixed priority, NCH=2: req[0] word read @0x100, with req[1] asserted in the same cycle. Required: channel 0 granted first; mem_a = 0x100..0x103 in cycles 1-4; done[0] at cycle 6; then channel 1 starts with first address in cycle 6.
- Sign extension: memory[0x20] = 0x80; half read with sext=1 -> rdata 0xFFFF??80 upper bits per byte1. Byte read with sext=1 -> 0xFFFFFF80; with sext=0 -> 0x00000080.
- Fetch, size 11: @0x0 with bytes 0x01,0x45 -> 2 bytes, rdata 0x00004501, done cycle 4. Bytes 0x13,0,0,0 -> 4 bytes, rdata 0x00000013, done cycle 6.
- IO stall: word write 0xAABBCCDD @0x30000 with io_buffer_full high for cycles 2-4. Required: byte 0xDD written in cycle 1; mem_wr low and mem_a held at 0x30001 through cycle 4; remaining bytes written cycles 5-7; done at cycle 8.
- Flush: FLUSH_MASK=2'b01; flush at cycle 2 of a channel-0 word read -> no done[0], IDLE next. Flush during a channel-0 write -> write completes with done.
- Round-robin, NCH=3: all three req held continuously -> grant order 0,1,2,0; async rst_in mid-transfer -> all outputs 0 immediately.
